// File: rtl/io_pkg.sv
// io_pkg: shared constants for the board input-conditioning stage.
//   IO_TICK_CYCLES : default sample-tick period in clocks (10 ms at 50 MHz)
//   IO_SAMPLES     : default consecutive disagreeing ticks needed to flip a level
//   IO_SW_RST      : per-bit reset level of switch paths (off)
//   IO_BTN_RST     : per-bit reset level of button paths (released, active-low)
package io_pkg;

    localparam int   IO_TICK_CYCLES = 500000;
    localparam int   IO_SAMPLES     = 3;

    localparam logic IO_SW_RST  = 1'b0;
    localparam logic IO_BTN_RST = 1'b1;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-FF synchroniser plus tick-sampled agreement counter for one
// raw asynchronous input.
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_raw    : raw asynchronous input
//   i_tick   : one-cycle sample strobe shared by all bits
//   o_stable : debounced level (the stable register itself)
// The level flips only after SAMPLES consecutive ticks at which the
// synchronised input disagrees with the current stable level; any agreeing
// tick restarts qualification.
module debounce_bit
    import io_pkg::*;
#(
    parameter int   SAMPLES = IO_SAMPLES,
    parameter logic RST_VAL = IO_SW_RST
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_stable
);

    localparam int            CW       = $clog2(SAMPLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);

    logic          meta_q,   meta_d;
    logic          sync_q,   sync_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    always_comb begin
        meta_d   = i_raw;
        sync_d   = meta_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (i_tick) begin
            if (sync_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q   <= RST_VAL;
            sync_q   <= RST_VAL;
            stable_q <= RST_VAL;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_stable = stable_q;

endmodule

// File: rtl/io_in_cond.sv
// io_in_cond: conditions raw board switches and active-low push-buttons for
// the core's LSU input space.
//   i_clk        : clock, rising edge
//   i_rst        : asynchronous active-high reset
//   i_sw_raw     : raw switches (asynchronous)
//   i_btn_raw    : raw buttons (asynchronous, 0 = pressed)
//   i_btn_clr    : per-bit one-cycle clear of the sticky press flag
//   o_io_sw      : debounced switches
//   o_io_btn     : debounced buttons, still active-low
//   o_btn_press  : one-cycle pulse the cycle after a debounced press (1->0)
//   o_btn_sticky : latched press flag, cleared by i_btn_clr
// Holds the shared sample-tick prescaler, the press-edge registers and the
// sticky flags; every bit is debounced by its own debounce_bit.
module io_in_cond
    import io_pkg::*;
#(
    parameter int N_SW        = 32,
    parameter int N_BTN       = 4,
    parameter int TICK_CYCLES = IO_TICK_CYCLES,
    parameter int SAMPLES     = IO_SAMPLES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SW-1:0]  i_sw_raw,
    input  logic [N_BTN-1:0] i_btn_raw,
    input  logic [N_BTN-1:0] i_btn_clr,
    output logic [N_SW-1:0]  o_io_sw,
    output logic [N_BTN-1:0] o_io_btn,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_btn_sticky
);

    localparam int            PW         = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;

    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_prev_q,  btn_prev_d;
    logic [N_BTN-1:0] press_q,     press_d;
    logic [N_BTN-1:0] sticky_q,    sticky_d;

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    for (genvar g = 0; g < N_SW; g++) begin : g_sw
        debounce_bit #(
            .SAMPLES (SAMPLES),
            .RST_VAL (IO_SW_RST)
        ) u_db (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_raw    (i_sw_raw[g]),
            .i_tick   (tick),
            .o_stable (o_io_sw[g])
        );
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        debounce_bit #(
            .SAMPLES (SAMPLES),
            .RST_VAL (IO_BTN_RST)
        ) u_db (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_raw    (i_btn_raw[g]),
            .i_tick   (tick),
            .o_stable (btn_stable[g])
        );
    end

    // The sticky flag is set by the pulse being formed (so it rises with
    // o_btn_press) and also by the pulse currently on o_btn_press, so a clear
    // issued while the pulse is visible loses to the set.
    always_comb begin
        btn_prev_d = btn_stable;
        press_d    = btn_prev_q & ~btn_stable;
        sticky_d   = (sticky_q & ~i_btn_clr) | press_d | press_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc_q    <= '0;
            btn_prev_q <= {N_BTN{IO_BTN_RST}};
            press_q    <= '0;
            sticky_q   <= '0;
        end else begin
            presc_q    <= presc_d;
            btn_prev_q <= btn_prev_d;
            press_q    <= press_d;
            sticky_q   <= sticky_d;
        end
    end

    assign o_io_btn     = btn_stable;
    assign o_btn_press  = press_q;
    assign o_btn_sticky = sticky_q;

endmodule

// File: tb/tb_io_in_cond.sv
module tb_io_in_cond;

    localparam int T  = 4;
    localparam int S  = 3;
    localparam int NB = 36;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sw_raw;
    logic [3:0]  btn_raw;
    logic [3:0]  btn_clr;
    logic [31:0] io_sw;
    logic [3:0]  io_btn;
    logic [3:0]  btn_press;
    logic [3:0]  btn_sticky;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    io_in_cond #(
        .N_SW        (32),
        .N_BTN       (4),
        .TICK_CYCLES (T),
        .SAMPLES     (S)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sw_raw     (sw_raw),
        .i_btn_raw    (btn_raw),
        .i_btn_clr    (btn_clr),
        .o_io_sw      (io_sw),
        .o_io_btn     (io_btn),
        .o_btn_press  (btn_press),
        .o_btn_sticky (btn_sticky)
    );

    // Reference model: bits 0..31 are switches, 32..35 are buttons.
    int        m_tick_ctr;
    bit [35:0] m_stage1, m_stage2, m_level;
    int        m_run [NB];
    bit [3:0]  m_fell_last, m_press, m_sticky;

    task automatic model_reset();
        m_tick_ctr  = 0;
        m_stage1    = {4'hF, 32'h0};
        m_stage2    = {4'hF, 32'h0};
        m_level     = {4'hF, 32'h0};
        for (int i = 0; i < NB; i++) m_run[i] = 0;
        m_fell_last = '0;
        m_press     = '0;
        m_sticky    = '0;
    endtask

    task automatic model_edge();
        bit        is_tick;
        bit [3:0]  btn_before;
        bit [3:0]  new_press;
        is_tick    = (m_tick_ctr % T) == (T - 1);
        m_tick_ctr = is_tick ? 0 : m_tick_ctr + 1;
        btn_before = m_level[35:32];
        if (is_tick) begin
            for (int i = 0; i < NB; i++) begin
                if (m_stage2[i] == m_level[i]) m_run[i] = 0;
                else if (m_run[i] + 1 >= S) begin
                    m_level[i] = m_stage2[i];
                    m_run[i]   = 0;
                end else m_run[i] = m_run[i] + 1;
            end
        end
        m_stage2    = m_stage1;
        m_stage1    = {btn_raw, sw_raw};
        new_press   = m_fell_last;
        m_sticky    = (m_sticky & ~btn_clr) | new_press | m_press;
        m_press     = new_press;
        m_fell_last = btn_before & ~m_level[35:32];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("io_sw",      io_sw,              m_level[31:0]);
        check("io_btn",     32'(io_btn),        32'(m_level[35:32]));
        check("btn_press",  32'(btn_press),     32'(m_press));
        check("btn_sticky", 32'(btn_sticky),    32'(m_sticky));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        compare_all();
    endtask

    task automatic pulse_reset(input int hold_edges);
        #3 rst = 1'b1;
        #1;
        check("rst_io_sw",      io_sw,           32'h0);
        check("rst_io_btn",     32'(io_btn),     32'hF);
        check("rst_btn_press",  32'(btn_press),  32'h0);
        check("rst_btn_sticky", 32'(btn_sticky), 32'h0);
        model_reset();
        repeat (hold_edges) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        int  n;
        int  fall_at, press_at, press_cnt;
        bit  seen, found;

        rst     = 1'b1;
        sw_raw  = '0;
        btn_raw = 4'hF;
        btn_clr = '0;
        model_reset();
        #12 rst = 1'b0;

        // Reset asserted mid-cycle with random raw activity
        repeat (3) step();
        sw_raw  = $urandom;
        btn_raw = 4'($urandom);
        repeat (6) step();
        pulse_reset(1);
        sw_raw  = '0;
        btn_raw = 4'hF;
        repeat (8) step();

        // Clean switch edge on bit 5
        sw_raw[5] = 1'b1;
        seen = 1'b0;
        n    = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (!seen && io_sw[5]) begin
                seen = 1'b1;
                n    = k;
            end
            check("sw_others_quiet", io_sw & ~32'h20, 32'h0);
        end
        check("sw5_rose", 32'(seen), 32'h1);
        check("sw5_latency_window", 32'(n >= 11 && n <= 14), 32'h1);

        // Bounce rejection on bit 0
        for (int k = 0; k < 40; k++) begin
            if (k % 5 == 0) sw_raw[0] = ~sw_raw[0];
            step();
            check("bounce_sw0", 32'(io_sw[0]), 32'h0);
        end
        sw_raw[0] = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            check("bounce_sw0_hold", 32'(io_sw[0]), 32'h0);
        end

        // Button 2 press then release
        fall_at   = 0;
        press_at  = 0;
        press_cnt = 0;
        btn_raw[2] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 31) btn_raw[2] = 1'b1;
            step();
            if (fall_at == 0 && !io_btn[2]) fall_at = k;
            if (btn_press[2]) begin
                press_cnt++;
                press_at = k;
            end
            if (k > 30) check("sticky2_through_release", 32'(btn_sticky[2]), 32'h1);
        end
        check("btn2_fell", 32'(fall_at != 0), 32'h1);
        check("btn2_press_count", 32'(press_cnt), 32'h1);
        check("btn2_press_after_fall", 32'(press_at), 32'(fall_at + 1));
        check("btn2_released", 32'(io_btn[2]), 32'h1);
        btn_clr[2] = 1'b1;
        step();
        btn_clr[2] = 1'b0;
        check("sticky2_cleared", 32'(btn_sticky[2]), 32'h0);

        // Clear in the same cycle as the press pulse, then a lone clear
        btn_raw[1] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (btn_press[1]) found = 1'b1;
        end
        check("btn1_press_seen", 32'(found), 32'h1);
        btn_clr[1] = 1'b1;
        step();
        btn_clr[1] = 1'b0;
        check("clr_vs_set_sticky1", 32'(btn_sticky[1]), 32'h1);
        repeat (3) step();
        btn_clr[1] = 1'b1;
        step();
        btn_clr[1] = 1'b0;
        check("lone_clr_sticky1", 32'(btn_sticky[1]), 32'h0);
        btn_raw[1] = 1'b1;
        repeat (20) step();

        // Reset in the middle of qualifying switch 3
        sw_raw[3] = 1'b1;
        repeat (9) step();
        check("sw3_not_yet", 32'(io_sw[3]), 32'h0);
        pulse_reset(1);
        seen = 1'b0;
        n    = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (!seen && io_sw[3]) begin
                seen = 1'b1;
                n    = k;
            end
        end
        check("sw3_requal_latency", 32'(n), 32'd12);

        // Randomised segments checked against the model every cycle
        for (int seg = 0; seg < 40; seg++) begin
            int hold;
            sw_raw  = $urandom;
            btn_raw = 4'($urandom);
            hold    = $urandom_range(1, 20);
            for (int k = 0; k < hold; k++) begin
                btn_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                step();
            end
            btn_clr = '0;
            if (seg == 20) pulse_reset(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
